// File: rtl/l2_write_buffer.sv
// Write-back buffer between the cache arbiter and L2: absorbs dirty-line
// writebacks in a small FIFO, serves read hits locally, drains to L2 when idle.
module l2_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  arb_mem_address,
  input  logic         arb_mem_read,
  input  logic         arb_mem_write,
  input  logic [127:0] arb_mem_wdata,
  output logic         arb_mem_resp,
  output logic [127:0] arb_mem_rdata,
  output logic [15:0]  l2c_mem_address,
  output logic         l2c_mem_read,
  output logic         l2c_mem_write,
  output logic [127:0] l2c_mem_wdata,
  input  logic         l2c_mem_resp,
  input  logic [127:0] l2c_mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, L2_READ, DRAIN, ACK} state_t;

  state_t state, state_nxt;

  logic [DEPTH-1:0]         valid;
  logic [DEPTH-1:0][11:0]   line;
  logic [DEPTH-1:0][127:0]  data;
  logic [PW-1:0]            head, tail;
  logic [PW:0]              count;

  logic [11:0]      req_line;
  logic [DEPTH-1:0] match;
  logic             hit, full;
  logic [PW-1:0]    hit_idx;

  logic rd_hit, rd_miss, rd_done, coalesce, alloc, drain, drain_done;

  assign req_line = arb_mem_address[15:4];

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = valid[i] && (line[i] == req_line);
  end

  assign hit  = |match;
  assign full = (count == FULL_CNT);

  // Valid lines are unique, so at most one match bit is set.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (match[i]) hit_idx = PW'(i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Upstream requests are only evaluated in IDLE, so the head being drained
  // can never be coalesced into: a matching write waits out the drain.
  always_comb begin
    state_nxt  = state;
    rd_hit     = 1'b0;
    rd_miss    = 1'b0;
    rd_done    = 1'b0;
    coalesce   = 1'b0;
    alloc      = 1'b0;
    drain      = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (arb_mem_read) begin
          if (hit) begin
            rd_hit    = 1'b1;
            state_nxt = ACK;
          end else begin
            rd_miss   = 1'b1;
            state_nxt = L2_READ;
          end
        end else if (arb_mem_write && hit) begin
          coalesce  = 1'b1;
          state_nxt = ACK;
        end else if (arb_mem_write && !full) begin
          alloc     = 1'b1;
          state_nxt = ACK;
        end else if (count != '0) begin
          drain     = 1'b1;
          state_nxt = DRAIN;
        end
      end
      L2_READ: begin
        if (l2c_mem_resp) begin
          rd_done   = 1'b1;
          state_nxt = ACK;
        end
      end
      DRAIN: begin
        if (l2c_mem_resp) begin
          drain_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Line storage needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (coalesce) data[hit_idx] <= arb_mem_wdata;
    if (alloc) begin
      data[tail] <= arb_mem_wdata;
      line[tail] <= req_line;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid           <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      arb_mem_resp    <= 1'b0;
      arb_mem_rdata   <= '0;
      l2c_mem_read    <= 1'b0;
      l2c_mem_write   <= 1'b0;
      l2c_mem_address <= '0;
      l2c_mem_wdata   <= '0;
    end else begin
      arb_mem_resp  <= (state_nxt == ACK);
      l2c_mem_read  <= (state_nxt == L2_READ);
      l2c_mem_write <= (state_nxt == DRAIN);

      if (rd_hit)  arb_mem_rdata <= data[hit_idx];
      if (rd_done) arb_mem_rdata <= l2c_mem_rdata;

      if (rd_miss) l2c_mem_address <= arb_mem_address;
      if (drain) begin
        l2c_mem_address <= {line[head], 4'b0};
        l2c_mem_wdata   <= data[head];
      end

      // Allocation and drain completion happen in different states.
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
        count       <= count + 1'b1;
      end else if (drain_done) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
        count       <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed bench for l2_write_buffer with a latency-programmable L2 model.
module tb_l2_write_buffer;

  logic         clk, rst_n;
  logic [15:0]  arb_mem_address;
  logic         arb_mem_read, arb_mem_write;
  logic [127:0] arb_mem_wdata;
  logic         arb_mem_resp;
  logic [127:0] arb_mem_rdata;
  logic [15:0]  l2c_mem_address;
  logic         l2c_mem_read, l2c_mem_write;
  logic [127:0] l2c_mem_wdata;
  logic         l2c_mem_resp;
  logic [127:0] l2c_mem_rdata;

  localparam logic [127:0] DA = {4{32'hA5A5_0001}};
  localparam logic [127:0] DB = {4{32'hB6B6_0002}};
  localparam logic [127:0] DC = {4{32'hC7C7_0003}};
  localparam logic [127:0] DD = {4{32'hD8D8_0004}};
  localparam logic [127:0] DE = {4{32'hE9E9_0005}};

  l2_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .arb_mem_address(arb_mem_address), .arb_mem_read(arb_mem_read),
    .arb_mem_write(arb_mem_write), .arb_mem_wdata(arb_mem_wdata),
    .arb_mem_resp(arb_mem_resp), .arb_mem_rdata(arb_mem_rdata),
    .l2c_mem_address(l2c_mem_address), .l2c_mem_read(l2c_mem_read),
    .l2c_mem_write(l2c_mem_write), .l2c_mem_wdata(l2c_mem_wdata),
    .l2c_mem_resp(l2c_mem_resp), .l2c_mem_rdata(l2c_mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int errs    = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // L2 model: responds l2_lat cycles after a request is seen, logs every transfer.
  bit             l2_stall = 1'b0;
  int             l2_lat   = 0;
  int             l2_wait  = 0;
  bit             lg_wr[$];
  logic [15:0]    lg_addr[$];
  logic [127:0]   lg_data[$];

  initial begin
    l2c_mem_resp  = 1'b0;
    l2c_mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      l2c_mem_resp  = 1'b0;
      l2c_mem_rdata = '0;
      if (!rst_n || !(l2c_mem_read || l2c_mem_write)) l2_wait = 0;
      else if (!l2_stall) begin
        if (l2_wait >= l2_lat) begin
          l2c_mem_resp = 1'b1;
          if (l2c_mem_read) l2c_mem_rdata = DC;
          lg_wr.push_back(l2c_mem_write);
          lg_addr.push_back(l2c_mem_address);
          lg_data.push_back(l2c_mem_wdata);
          l2_wait = 0;
        end else l2_wait++;
      end
    end
  end

  // Protocol monitors.
  int both_hi = 0, dbl_resp = 0, rd_cyc = 0;
  bit resp_q  = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (l2c_mem_read && l2c_mem_write) both_hi++;
      if (arb_mem_resp && resp_q) dbl_resp++;
      if (l2c_mem_read) rd_cyc++;
    end
    resp_q = arb_mem_resp;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Raises a request and holds it until arb_mem_resp; lat counts cycles from raise.
  task automatic do_req(input bit wr, input logic [15:0] a, input logic [127:0] d,
                        output int lat, output logic [127:0] rd);
    arb_mem_address = a;
    arb_mem_wdata   = d;
    arb_mem_write   = wr;
    arb_mem_read    = !wr;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (arb_mem_resp) break;
    end
    rd = arb_mem_rdata;
    if (!arb_mem_resp) chk("req_timeout", 128'(arb_mem_resp), 128'(1));
    arb_mem_read  = 1'b0;
    arb_mem_write = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    while (n < 500 && (dut.count != 0 || l2c_mem_write || l2c_mem_read)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", 128'(dut.count), 128'(0));
    idle(2);
  endtask

  int lat, base, rc0;
  logic [127:0] rd;

  initial begin
    rst_n           = 1'b0;
    arb_mem_address = 16'h1230;
    arb_mem_read    = 1'b1;
    arb_mem_write   = 1'b0;
    arb_mem_wdata   = DA;

    // Reset with a request held high.
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_resp",  128'(arb_mem_resp),    128'(0));
      chk("rst_rdata", arb_mem_rdata,         128'(0));
      chk("rst_l2rd",  128'(l2c_mem_read),    128'(0));
      chk("rst_l2wr",  128'(l2c_mem_write),   128'(0));
      chk("rst_addr",  128'(l2c_mem_address), 128'(0));
      chk("rst_wdata", l2c_mem_wdata,         128'(0));
      chk("rst_count", 128'(dut.count),       128'(0));
    end
    arb_mem_read = 1'b0;
    rst_n        = 1'b1;
    idle(2);
    chk("post_rst_log", 128'(lg_addr.size()), 128'(0));

    // Write then read-hit with L2 stalled.
    l2_stall = 1'b1;
    l2_lat   = 0;
    rc0      = rd_cyc;
    base     = lg_addr.size();
    do_req(1'b1, 16'h1230, DA, lat, rd);
    chk("hit_wr_lat", 128'(lat), 128'(1));
    do_req(1'b0, 16'h1230, '0, lat, rd);
    chk("hit_rd_lat",  128'(lat), 128'(2));
    chk("hit_rd_data", rd, DA);
    chk("hit_no_l2rd", 128'(rd_cyc - rc0), 128'(0));
    l2_stall = 1'b0;
    wait_drained();
    chk("hit_drain_n",    128'(lg_addr.size() - base), 128'(1));
    chk("hit_drain_addr", 128'(lg_addr[base]), 128'(16'h1230));
    chk("hit_drain_data", lg_data[base], DA);

    // Four writes, drained in FIFO order.
    base = lg_addr.size();
    idle(1);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 16'((i + 1) * 16), DD + 128'(i), lat, rd);
      chk("fifo_wr_lat", 128'(lat), 128'(i == 0 ? 1 : 2));
    end
    wait_drained();
    chk("fifo_n", 128'(lg_addr.size() - base), 128'(4));
    for (int i = 0; i < 4; i++) begin
      chk("fifo_addr", 128'(lg_addr[base + i]), 128'(16'((i + 1) * 16)));
      chk("fifo_data", lg_data[base + i], DD + 128'(i));
      chk("fifo_is_wr", 128'(lg_wr[base + i]), 128'(1));
    end

    // Fill with slow L2, then a fifth write waits for one drain.
    l2_lat = 5;
    base   = lg_addr.size();
    idle(1);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b1, 16'((i + 6) * 16), DB + 128'(i), lat, rd);
      chk("full_wr_lat", 128'(lat), 128'(i == 0 ? 1 : 2));
    end
    do_req(1'b1, 16'h0050, DE, lat, rd);
    chk("full_5th_lat",   128'(lat), 128'(9));
    chk("full_1st_drain", 128'(lg_addr.size() - base), 128'(1));
    chk("full_count",     128'(dut.count), 128'(4));
    wait_drained();
    chk("full_n", 128'(lg_addr.size() - base), 128'(5));
    for (int i = 0; i < 4; i++)
      chk("full_order", 128'(lg_addr[base + i]), 128'(16'((i + 6) * 16)));
    chk("full_5th_addr", 128'(lg_addr[base + 4]), 128'(16'h0050));
    chk("full_5th_data", lg_data[base + 4], DE);

    // Coalescing write.
    l2_lat = 0;
    base   = lg_addr.size();
    idle(1);
    do_req(1'b1, 16'h0100, DA, lat, rd);
    chk("coal_lat_a", 128'(lat), 128'(1));
    do_req(1'b1, 16'h0100, DB, lat, rd);
    chk("coal_lat_b", 128'(lat), 128'(2));
    chk("coal_count", 128'(dut.count), 128'(1));
    wait_drained();
    chk("coal_n",    128'(lg_addr.size() - base), 128'(1));
    chk("coal_addr", 128'(lg_addr[base]), 128'(16'h0100));
    chk("coal_data", lg_data[base], DB);

    // Read miss overtakes a pending drain.
    base = lg_addr.size();
    idle(1);
    do_req(1'b1, 16'h0300, DD, lat, rd);
    chk("miss_wr_lat", 128'(lat), 128'(1));
    do_req(1'b0, 16'h0200, '0, lat, rd);
    chk("miss_lat",  128'(lat), 128'(3));
    chk("miss_data", rd, DC);
    wait_drained();
    chk("miss_n",      128'(lg_addr.size() - base), 128'(2));
    chk("miss_first",  128'(lg_wr[base]), 128'(0));
    chk("miss_raddr",  128'(lg_addr[base]), 128'(16'h0200));
    chk("miss_second", 128'(lg_wr[base + 1]), 128'(1));
    chk("miss_waddr",  128'(lg_addr[base + 1]), 128'(16'h0300));
    chk("miss_wdata",  lg_data[base + 1], DD);

    // Reset in the middle of a stalled drain.
    l2_stall = 1'b1;
    base     = lg_addr.size();
    idle(1);
    do_req(1'b1, 16'h0400, DE, lat, rd);
    idle(2);
    chk("mid_drain_wr", 128'(l2c_mem_write), 128'(1));
    rst_n = 1'b0;
    idle(1);
    chk("mid_rst_wr",    128'(l2c_mem_write), 128'(0));
    chk("mid_rst_count", 128'(dut.count), 128'(0));
    rst_n    = 1'b1;
    l2_stall = 1'b0;
    idle(3);
    chk("mid_rst_quiet", 128'(l2c_mem_write), 128'(0));
    chk("mid_rst_log",   128'(lg_addr.size() - base), 128'(0));

    chk("both_l2_req", 128'(both_hi), 128'(0));
    chk("resp_pulse",  128'(dbl_resp), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/l2_write_buffer.md
# l2_write_buffer

Write-back buffer inserted between the cache arbiter's L2-side port and the L2 cache. It absorbs dirty-line writebacks from the arbiter in a small FIFO and acknowledges them in one cycle. Reads that match a buffered line are served locally; read misses are forwarded to L2 ahead of pending writebacks. Buffered lines drain to L2 in FIFO order whenever no read is waiting.

## Interface
- DEPTH, 4, number of line entries; power of two, ≥2
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, synchronous and active-low
- arb_mem_address  in  16  line request address from arbiter; line address = bits [15:4]
- arb_mem_read  in  1  read request; held with address until arb_mem_resp
- arb_mem_write  in  1  write request; held with address/wdata until arb_mem_resp; never high together with arb_mem_read
- arb_mem_wdata  in  128  writeback line
- arb_mem_resp  out  1  one-cycle completion pulse to arbiter
- arb_mem_rdata  out  128  read line, valid while arb_mem_resp=1
- l2c_mem_address  out  16  request address to L2
- l2c_mem_read  out  1  read request to L2, held until l2c_mem_resp
- l2c_mem_write  out  1  write request to L2, held until l2c_mem_resp
- l2c_mem_wdata  out  128  drained line
- l2c_mem_resp  in  1  L2 completion pulse
- l2c_mem_rdata  in  128  L2 read line, valid with l2c_mem_resp

## Operation
- Storage: DEPTH entries {valid, line_addr[11:0], data[127:0]}, circular head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count 0..DEPTH.
- FSM states: IDLE, L2_READ, DRAIN, ACK.
- IDLE priority: upstream read > upstream write > drain.
  - Read, line matches a valid entry: load arb_mem_rdata from that entry → ACK. No L2 access. Matches are unique, so there is no ambiguity.
  - Read, no match: latch address → L2_READ.
  - Write, matches a valid entry that is not the head currently being drained: overwrite that entry's data in place (coalesce) → ACK. Count is unchanged.
  - Write, no match, count<DEPTH: write at tail, tail+1, count+1 → ACK.
  - Write, no match, count=DEPTH: not accepted. Falls through to drain.
  - Otherwise, count>0: latch head entry → DRAIN.
- L2_READ: l2c_mem_read=1 with the latched address. On l2c_mem_resp, capture l2c_mem_rdata into arb_mem_rdata → ACK.
- DRAIN: l2c_mem_write=1 with head address/data, where the address is {line_addr,4'b0}. The head entry is locked; a write matching it is not coalesced. On l2c_mem_resp, clear head valid, head+1, count−1 → IDLE. A started drain always completes; a read arriving meanwhile waits.
- ACK: arb_mem_resp=1 for exactly this cycle. Upstream requests are ignored → IDLE. This prevents re-accepting a request still held high.
- Exactly one of l2c_mem_read / l2c_mem_write is high outside IDLE/ACK; both are 0 in IDLE/ACK.

## Timing
- All outputs are registered.
- Reset (rst_n=0 at an edge): state=IDLE, all valid=0, head=tail=count=0, and every output is 0 (arb_mem_resp, arb_mem_rdata, l2c_mem_read, l2c_mem_write, l2c_mem_address, l2c_mem_wdata).
  - Reset mid-drain or mid-read: buffered lines are discarded and l2c requests drop the next cycle. L2 is reset in the same cycle.
- Write accept or read hit: request high in IDLE at cycle N → arb_mem_resp at N+1. Best-case throughput is one request per 2 cycles.
- Read miss: request at N → l2c_mem_read from N+1. l2c_mem_resp at cycle M → arb_mem_resp and rdata at M+1.
- Drain: decided at N → l2c_mem_write from N+1 through the resp cycle M. Entry is freed at M's edge; IDLE at M+1.
- Full with a non-matching write: the write is accepted at the earliest IDLE after a drain completes. Latency is the L2 write latency + 3.
- Write matching the draining head: waits for the drain to complete, then allocates a new entry.
- Pointer wrap: tail=DEPTH−1 plus an allocate gives tail=0; likewise for head.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with requests high → all outputs 0, count=0, no l2c activity.
- Write 0x1230 with data A, then read 0x1230 (L2 stalled) → arb_mem_resp one cycle after each request; the read returns A; l2c_mem_read never asserted.
- Four writes to 0x0010/0x0020/0x0030/0x0040 with L2 idle → drained in that order with l2c_mem_address 0x0010…0x0040; count returns to 0.
- Fill DEPTH=4 while L2 resp is delayed 5 cycles, then issue a fifth write 0x0050 → no resp until the first drain's l2c_mem_resp, then the write is accepted; pointer wrap is exercised.
- Write 0x0100 with A, then write 0x0100 with B before it drains → single entry, one L2 write with data B.
- Read miss 0x0200 issued while a drain is pending → the read goes to L2 first; L2 returns C; arb_mem_rdata=C; the drain follows.
